// File: rtl/demux_1_16_secuencial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_1_16_secuencial: serial-to-parallel loader for one 16-word block      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_1_16_secuencial #(
  parameter int BITS_DATOS = 8
) (
  input  logic                  reloj,
  input  logic                  reset_n,
  input  logic [BITS_DATOS-1:0] entrada,
  input  logic                  entrada_valida,
  output logic                  entrada_lista,
  input  logic                  bloque_tomado,
  input  logic                  reiniciar_bloque,
  output logic [3:0]            indice,
  output logic                  bloque_valido,
  output logic [BITS_DATOS-1:0] salida_1,
  output logic [BITS_DATOS-1:0] salida_2,
  output logic [BITS_DATOS-1:0] salida_3,
  output logic [BITS_DATOS-1:0] salida_4,
  output logic [BITS_DATOS-1:0] salida_5,
  output logic [BITS_DATOS-1:0] salida_6,
  output logic [BITS_DATOS-1:0] salida_7,
  output logic [BITS_DATOS-1:0] salida_8,
  output logic [BITS_DATOS-1:0] salida_9,
  output logic [BITS_DATOS-1:0] salida_10,
  output logic [BITS_DATOS-1:0] salida_11,
  output logic [BITS_DATOS-1:0] salida_12,
  output logic [BITS_DATOS-1:0] salida_13,
  output logic [BITS_DATOS-1:0] salida_14,
  output logic [BITS_DATOS-1:0] salida_15,
  output logic [BITS_DATOS-1:0] salida_16
);

  typedef enum logic [0:0] {
    LLENANDO = 1'b0,
    LLENO    = 1'b1
  } estado_t;

  localparam logic [3:0] c_ultimo = 4'd15;

  estado_t               r_estado;
  estado_t               w_estado_sig;
  logic [3:0]            r_indice;
  logic [3:0]            w_indice_sig;
  logic                  w_escribir;
  logic [BITS_DATOS-1:0] r_slots [16];

  always_comb begin
    w_estado_sig = r_estado;
    w_indice_sig = r_indice;
    w_escribir   = 1'b0;
    // An abort outranks everything, including a coincident transfer.
    if (reiniciar_bloque) begin
      w_estado_sig = LLENANDO;
      w_indice_sig = 4'd0;
    end else begin
      case (r_estado)
        LLENANDO: begin
          if (entrada_valida) begin
            w_escribir   = 1'b1;
            w_indice_sig = r_indice + 4'd1;
            if (r_indice == c_ultimo) begin
              w_estado_sig = LLENO;
            end
          end
        end
        LLENO: begin
          if (bloque_tomado) begin
            w_estado_sig = LLENANDO;
          end
        end
        default: begin
          w_estado_sig = LLENANDO;
          w_indice_sig = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      r_estado <= LLENANDO;
      r_indice <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      r_estado <= w_estado_sig;
      r_indice <= w_indice_sig;
      if (w_escribir) begin
        r_slots[r_indice] <= entrada;
      end
    end
  end

  assign entrada_lista = (r_estado == LLENANDO);
  assign bloque_valido = (r_estado == LLENO);
  assign indice        = r_indice;

  assign salida_1  = r_slots[0];
  assign salida_2  = r_slots[1];
  assign salida_3  = r_slots[2];
  assign salida_4  = r_slots[3];
  assign salida_5  = r_slots[4];
  assign salida_6  = r_slots[5];
  assign salida_7  = r_slots[6];
  assign salida_8  = r_slots[7];
  assign salida_9  = r_slots[8];
  assign salida_10 = r_slots[9];
  assign salida_11 = r_slots[10];
  assign salida_12 = r_slots[11];
  assign salida_13 = r_slots[12];
  assign salida_14 = r_slots[13];
  assign salida_15 = r_slots[14];
  assign salida_16 = r_slots[15];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_16_secuencial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_demux_1_16_secuencial: randomized bench with a word-count block model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_demux_1_16_secuencial;

  logic       reloj = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] entrada = 8'd0;
  logic       entrada_valida = 1'b0;
  logic       entrada_lista;
  logic       bloque_tomado = 1'b0;
  logic       reiniciar_bloque = 1'b0;
  logic [3:0] indice;
  logic       bloque_valido;
  logic [7:0] sal [16];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: slot contents, words received in the current block, block complete.
  logic [7:0] m_slots [16];
  int         m_count = 0;
  bit         m_full = 1'b0;

  always #5 reloj = ~reloj;

  demux_1_16_secuencial #(.BITS_DATOS(8)) dut (
    .reloj            (reloj),
    .reset_n          (reset_n),
    .entrada          (entrada),
    .entrada_valida   (entrada_valida),
    .entrada_lista    (entrada_lista),
    .bloque_tomado    (bloque_tomado),
    .reiniciar_bloque (reiniciar_bloque),
    .indice           (indice),
    .bloque_valido    (bloque_valido),
    .salida_1  (sal[0]),  .salida_2  (sal[1]),  .salida_3  (sal[2]),  .salida_4  (sal[3]),
    .salida_5  (sal[4]),  .salida_6  (sal[5]),  .salida_7  (sal[6]),  .salida_8  (sal[7]),
    .salida_9  (sal[8]),  .salida_10 (sal[9]),  .salida_11 (sal[10]), .salida_12 (sal[11]),
    .salida_13 (sal[12]), .salida_14 (sal[13]), .salida_15 (sal[14]), .salida_16 (sal[15])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge reloj) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_slots[i] = 8'd0;
      m_count = 0;
      m_full  = 1'b0;
    end else if (reiniciar_bloque) begin
      m_count = 0;
      m_full  = 1'b0;
    end else if (!m_full) begin
      if (entrada_valida) begin
        m_slots[m_count] = entrada;
        m_count = m_count + 1;
        if (m_count == 16) begin
          m_count = 0;
          m_full  = 1'b1;
        end
      end
    end else if (bloque_tomado) begin
      m_full = 1'b0;
    end
  end

  always @(negedge reloj) begin
    if (chk_en) begin
      chk("indice", 32'(indice), 32'(m_count));
      chk("bloque_valido", 32'(bloque_valido), 32'(m_full));
      chk("entrada_lista", 32'(entrada_lista), 32'(!m_full));
      for (int i = 0; i < 16; i++)
        chk($sformatf("salida_%0d", i + 1), 32'(sal[i]), 32'(m_slots[i]));
    end
  end

  // Drive one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic cyc(input logic rn, input logic v, input logic [7:0] d,
                     input logic tk, input logic rb);
    @(negedge reloj);
    reset_n          = rn;
    entrada_valida   = v;
    entrada          = d;
    bloque_tomado    = tk;
    reiniciar_bloque = rb;
    @(posedge reloj);
    #1;
  endtask

  initial begin
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("rst_indice", 32'(indice), 32'd0);
    chk("rst_bloque_valido", 32'(bloque_valido), 32'd0);
    chk("rst_entrada_lista", 32'(entrada_lista), 32'd1);

    // 1: back-to-back fill
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) chk($sformatf("t1_salida_%0d", k), 32'(sal[k-1]), 32'(8'h0F + k));
    chk("t1_bloque_valido", 32'(bloque_valido), 32'd1);
    chk("t1_entrada_lista", 32'(entrada_lista), 32'd0);
    chk("t1_indice", 32'(indice), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // 2: same data with gaps
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      if (k == 14) chk("t2_not_yet_valid", 32'(bloque_valido), 32'd0);
      if (k != 15) cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    end
    chk("t2_bloque_valido", 32'(bloque_valido), 32'd1);
    chk("t2_salida_16", 32'(sal[15]), 32'h1F);

    // 3: valid ignored while full, then acknowledge
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t3_salida_1", 32'(sal[0]), 32'h10);
    chk("t3_salida_16", 32'(sal[15]), 32'h1F);
    chk("t3_bloque_valido", 32'(bloque_valido), 32'd0);
    chk("t3_entrada_lista", 32'(entrada_lista), 32'd1);
    chk("t3_indice", 32'(indice), 32'd0);

    // 4: abort after 7 words discards the coincident word
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    chk("t4_indice", 32'(indice), 32'd0);
    chk("t4_salida_8_kept", 32'(sal[7]), 32'h17);
    chk("t4_salida_7", 32'(sal[6]), 32'h36);
    cyc(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    chk("t4_salida_1", 32'(sal[0]), 32'h66);
    chk("t4_indice_after", 32'(indice), 32'd1);

    // 5: reset in the middle of a fill at indice 9
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    chk("t5_indice_pre", 32'(indice), 32'd9);
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) chk($sformatf("t5_salida_%0d", k + 1), 32'(sal[k]), 32'd0);
    chk("t5_indice", 32'(indice), 32'd0);
    chk("t5_bloque_valido", 32'(bloque_valido), 32'd0);
    chk("t5_entrada_lista", 32'(entrada_lista), 32'd1);

    // 6: two consecutive blocks
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 8'(k), 1'b0, 1'b0);
    chk("t6_first_salida_16", 32'(sal[15]), 32'h0F);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 8'(8'hF0 + k), 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) chk($sformatf("t6_salida_%0d", k), 32'(sal[k-1]), 32'(8'hEF + k));
    chk("t6_bloque_valido", 32'(bloque_valido), 32'd1);
    chk("t6_indice", 32'(indice), 32'd0);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 800; n++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) < 7),
          8'($urandom),
          ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 99) < 3));
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge reloj);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
